lcd_frame_writer: RTL

Formats recorder status (mode, elapsed seconds, playback speed) into a 2×16 ASCII frame. Hands the frame to the downstream LCD driver one character at a time over a valid/ready handshake. Sits between the recorder top-level control FSM and the LCD driver, which owns HD44780 timing and pin-level signalling. Redraws the frame only when the displayed status changes; issues exactly one clear command after each reset.

---
 rtl/lcd_pkg.sv | 77 +++++++
 rtl/lcd_frame_writer_if.sv | 18 +
 rtl/lcd_char_rom.sv | 34 +++
 rtl/lcd_frame_writer.sv | 104 ++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared types, frame geometry, ASCII constants and text helpers
//            for the recorder LCD frame writer.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  localparam int LCD_ROWS = 2;
  localparam int LCD_COLS = 16;

  typedef enum logic [2:0] {
    MODE_IDLE   = 3'd0,
    MODE_RECORD = 3'd1,
    MODE_PLAY   = 3'd2,
    MODE_PAUSE  = 3'd3
  } mode_e;

  localparam logic [1:0] S_CLR   = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic [7:0] c_ascii_space = 8'h20;
  localparam logic [7:0] c_ascii_zero  = 8'h30;

  localparam logic [127:0] c_str_idle   = "IDLE            ";
  localparam logic [127:0] c_str_record = "RECORD          ";
  localparam logic [127:0] c_str_play   = "PLAY            ";
  localparam logic [127:0] c_str_pause  = "PAUSE           ";
  localparam logic [127:0] c_str_error  = "ERROR           ";
  localparam logic [127:0] c_row1_tmpl  = "TIME 00s  SPD 0x";

  // Snapshot carries pre-converted decimal digits so no divider sits on the character path
  typedef struct packed {
    logic [2:0] mode;
    logic [5:0] sec;
    logic [2:0] speed;
    logic [2:0] tens;
    logic [3:0] ones;
  } snap_t;

  function automatic logic [2:0] sec_tens(input logic [5:0] s);
    if (s >= 6'd60)      return 3'd6;
    else if (s >= 6'd50) return 3'd5;
    else if (s >= 6'd40) return 3'd4;
    else if (s >= 6'd30) return 3'd3;
    else if (s >= 6'd20) return 3'd2;
    else if (s >= 6'd10) return 3'd1;
    else                 return 3'd0;
  endfunction

  function automatic logic [3:0] sec_ones(input logic [5:0] s);
    logic [5:0] base;
    base = 6'(sec_tens(s)) * 6'd10;
    return 4'(s - base);
  endfunction

  function automatic logic [127:0] mode_text(input logic [2:0] m);
    case (m)
      MODE_IDLE:   return c_str_idle;
      MODE_RECORD: return c_str_record;
      MODE_PLAY:   return c_str_play;
      MODE_PAUSE:  return c_str_pause;
      default:     return c_str_error;
    endcase
  endfunction

  // Column 0 is the leftmost (most significant) byte of a string literal
  function automatic logic [7:0] str_char(input logic [127:0] s, input logic [3:0] col);
    logic [6:0] lsb;
    lsb = 7'(8 * (15 - int'(col)));
    return s[lsb +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_frame_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_frame_writer_if
// Purpose  : Character-stream valid/ready link from frame writer to LCD driver.
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_frame_writer_if;
  logic       valid;
  logic       ready;
  logic       clr;
  logic       row;
  logic [3:0] col;
  logic [7:0] chr;

  modport master (output valid, clr, row, col, chr, input ready);
  modport slave  (input valid, clr, row, col, chr, output ready);
endinterface
`default_nettype wire

// File: rtl/lcd_char_rom.sv
`default_nettype none
// ============================================================================
// Module   : lcd_char_rom
// Purpose  : Combinational map from (row, col, snapshot) to the ASCII glyph.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_char_rom
  import lcd_pkg::*;
(
  input  logic       i_row,
  input  logic [3:0] i_col,
  input  logic [2:0] i_mode,
  input  logic [2:0] i_tens,
  input  logic [3:0] i_ones,
  input  logic [2:0] i_speed,
  output logic [7:0] o_char
);

  always_comb begin
    o_char = c_ascii_space;
    if (!i_row) begin
      o_char = str_char(mode_text(i_mode), i_col);
    end else begin
      case (i_col)
        4'd5:    o_char = c_ascii_zero + {5'b0, i_tens};
        4'd6:    o_char = c_ascii_zero + {4'b0, i_ones};
        4'd14:   o_char = c_ascii_zero + {5'b0, i_speed} + 8'd1;
        default: o_char = str_char(c_row1_tmpl, i_col);
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_frame_writer
// Purpose  : Renders recorder status into a 2x16 frame and streams it to the
//            LCD driver one character per handshake, redrawing on change.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_frame_writer
  import lcd_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [2:0]                i_mode,
  input  logic [5:0]                i_sec,
  input  logic [2:0]                i_speed,
  output logic                      o_busy,
  lcd_frame_writer_if.master        lcd
);

  localparam logic [3:0] c_last_col = 4'(LCD_COLS - 1);
  localparam logic       c_last_row = 1'(LCD_ROWS - 1);

  logic [1:0] r_state;
  logic       r_run;
  logic       r_row;
  logic [3:0] r_col;
  snap_t      r_snap;

  logic       w_hs;
  logic       w_changed;
  logic [7:0] w_char;
  snap_t      w_live;

  assign w_live    = '{mode: i_mode, sec: i_sec, speed: i_speed,
                       tens: sec_tens(i_sec), ones: sec_ones(i_sec)};
  assign w_changed = {i_mode, i_sec, i_speed} != {r_snap.mode, r_snap.sec, r_snap.speed};
  assign w_hs      = lcd.valid && lcd.ready;

  // r_run keeps valid low while reset is held even though the state is S_CLR
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_CLR;
      r_run   <= 1'b0;
      r_row   <= 1'b0;
      r_col   <= 4'd0;
      r_snap  <= '0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        S_CLR: begin
          if (w_hs) begin
            r_snap  <= w_live;
            r_row   <= 1'b0;
            r_col   <= 4'd0;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_hs) begin
            if (r_col == c_last_col) begin
              r_col <= 4'd0;
              if (r_row == c_last_row) begin
                r_row   <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_row <= 1'b1;
              end
            end else begin
              r_col <= r_col + 4'd1;
            end
          end
        end
        S_IDLE: begin
          if (w_changed) begin
            r_snap  <= w_live;
            r_row   <= 1'b0;
            r_col   <= 4'd0;
            r_state <= S_WRITE;
          end
        end
        default: r_state <= S_CLR;
      endcase
    end
  end

  lcd_char_rom u_rom (
    .i_row   (r_row),
    .i_col   (r_col),
    .i_mode  (r_snap.mode),
    .i_tens  (r_snap.tens),
    .i_ones  (r_snap.ones),
    .i_speed (r_snap.speed),
    .o_char  (w_char)
  );

  assign lcd.valid = r_run && (r_state != S_IDLE);
  assign lcd.clr   = r_run && (r_state == S_CLR);
  assign lcd.row   = r_row;
  assign lcd.col   = r_col;
  assign lcd.chr   = (r_state == S_WRITE) ? w_char : c_ascii_space;
  assign o_busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire
